// File: rtl/imem_fetch_sequencer_pkg.sv
// ============================================================================
//  Module      : imem_fetch_sequencer_pkg
//  Description : Shared state encodings and constants for the fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_fetch_sequencer_if.sv
// ============================================================================
//  Module      : imem_fetch_sequencer_if
//  Description : Loader, memory, control and decode-side signals of the fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_fetch_sequencer_if #(
    parameter int IDX_W = 3
);
    logic             ld_valid;
    logic             ld_ready;
    logic [IDX_W-1:0] ld_addr;
    logic [31:0]      ld_data;
    logic             ld_last;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             halt_req;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             imem_we;
    logic [IDX_W-1:0] imem_waddr;
    logic [31:0]      imem_wdata;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic [1:0]       state;

    modport master (
        input  ld_valid, ld_addr, ld_data, ld_last, redirect_valid, redirect_pc,
               halt_req, imem_rdata, if_ready,
        output ld_ready, imem_addr, imem_we, imem_waddr, imem_wdata,
               if_valid, if_pc, if_instr, state
    );

    modport slave (
        output ld_valid, ld_addr, ld_data, ld_last, redirect_valid, redirect_pc,
               halt_req, imem_rdata, if_ready,
        input  ld_ready, imem_addr, imem_we, imem_waddr, imem_wdata,
               if_valid, if_pc, if_instr, state
    );

endinterface

`default_nettype wire

// File: rtl/imem_fetch_sequencer_fetch_slot.sv
// ============================================================================
//  Module      : fetch_slot
//  Description : One-entry valid/ready register holding {pc, instr} toward decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_slot (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_load,
    input  wire logic        i_flush,
    input  wire logic        i_ready,
    input  wire logic [31:0] i_pc,
    input  wire logic [31:0] i_instr,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Flush dominates so a wrong-path entry never survives, even when accepted.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            pc_d    = i_pc;
            instr_d = i_instr;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_instr = instr_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_sequencer.sv
// ============================================================================
//  Module      : imem_fetch_sequencer
//  Description : PC owner, fetch FSM (LOAD/RUN/HALT) and loader write mux.
//                Boot loader port enabled by macro IMEM_LOADER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_sequencer
    import imem_fetch_sequencer_pkg::*;
#(
    parameter int          IMEM_DEPTH = 8,
    parameter int          IDX_W      = 3,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    imem_fetch_sequencer_if.master bus
);

    localparam int          c_unused_depth_w = $clog2(IMEM_DEPTH);
    localparam logic [31:0] c_reset_pc       = align_pc(RESET_PC);
`ifdef IMEM_LOADER_EN
    localparam state_t      c_init_state     = ST_LOAD;
`else
    localparam state_t      c_init_state     = ST_RUN;
    logic w_unused_ld;
    assign w_unused_ld = ^{bus.ld_valid, bus.ld_addr, bus.ld_data, bus.ld_last};
`endif

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             w_accept, w_free, w_load, w_flush;
    logic             w_ld_ready, w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [31:0]      w_wdata;

    assign w_accept = bus.if_valid & bus.if_ready;
    assign w_free   = ~bus.if_valid | w_accept;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        w_load     = 1'b0;
        w_flush    = 1'b0;
        w_ld_ready = 1'b0;
        w_we       = 1'b0;
        w_waddr    = '0;
        w_wdata    = 32'h0;
        case (state_q)
`ifdef IMEM_LOADER_EN
            ST_LOAD: begin
                w_ld_ready = 1'b1;
                w_we       = bus.ld_valid;
                w_waddr    = bus.ld_addr;
                w_wdata    = bus.ld_data;
                w_flush    = 1'b1;
                if (bus.ld_valid && bus.ld_last) begin
                    state_d = ST_RUN;
                    pc_d    = c_reset_pc;
                end
            end
`endif
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d    = align_pc(bus.redirect_pc);
                    w_flush = 1'b1;
                end else if (bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (w_free) begin
                    w_load = 1'b1;
                    pc_d   = pc_q + PC_STEP;
                end
            end
            // Slot drains through normal accept while halted; pc only moves on redirect.
            ST_HALT: begin
                if (bus.redirect_valid) begin
                    pc_d    = align_pc(bus.redirect_pc);
                    w_flush = 1'b1;
                end else if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = c_init_state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_init_state;
            pc_q    <= c_reset_pc;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ready (bus.if_ready),
        .i_pc    (pc_q),
        .i_instr (bus.imem_rdata),
        .o_valid (bus.if_valid),
        .o_pc    (bus.if_pc),
        .o_instr (bus.if_instr)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.ld_ready   = w_ld_ready;
    assign bus.imem_we    = w_we;
    assign bus.imem_waddr = w_waddr;
    assign bus.imem_wdata = w_wdata;
    assign bus.state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_sequencer.sv
// ============================================================================
//  Module      : tb_imem_fetch_sequencer
//  Description : Self-checking bench: behavioural model plus directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_sequencer;
    import imem_fetch_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_sequencer_if #(.IDX_W(3)) bus ();

    imem_fetch_sequencer #(.IMEM_DEPTH(8), .IDX_W(3), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef IMEM_LOADER_EN
    localparam logic [1:0] INIT_ST = 2'd0;
`else
    localparam logic [1:0] INIT_ST = 2'd1;
`endif

    logic [31:0] mem [8];
    assign bus.imem_rdata = mem[bus.imem_addr[4:2]];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    // Environment memory: written by the DUT's write port
    always @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // Reference model: architectural state advanced by the spec's priority rules
    logic [1:0]  m_st    = INIT_ST;
    logic [31:0] m_pc    = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_ipc   = 32'h0;
    logic [31:0] m_instr = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= INIT_ST; m_pc <= 32'h0; m_valid <= 1'b0; m_ipc <= 32'h0; m_instr <= 32'h0;
        end else if (m_st == 2'd0) begin
            if (bus.ld_valid && bus.ld_last) begin
                m_st <= 2'd1;
                m_pc <= 32'h0;
            end
        end else begin
            if (bus.redirect_valid) begin
                m_pc    <= bus.redirect_pc & ~32'h3;
                m_valid <= 1'b0;
            end else if (m_st == 2'd2 || bus.halt_req) begin
                if (m_valid && bus.if_ready) m_valid <= 1'b0;
                m_st <= bus.halt_req ? 2'd2 : 2'd1;
            end else if (!m_valid || bus.if_ready) begin
                m_valid <= 1'b1;
                m_ipc   <= m_pc;
                m_instr <= mem[m_pc[4:2]];
                m_pc    <= m_pc + 32'd4;
            end
        end
    end

    // Compare process
    always @(negedge clk) begin
        chk("state", {30'h0, bus.state}, {30'h0, m_st});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_valid});
        if (m_valid) begin
            chk("if_pc", bus.if_pc, m_ipc);
            chk("if_instr", bus.if_instr, m_instr);
        end
        chk("ld_ready", {31'h0, bus.ld_ready}, {31'h0, m_st == 2'd0});
        chk("imem_we", {31'h0, bus.imem_we}, {31'h0, (m_st == 2'd0) && bus.ld_valid});
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] p);
        for (int k = 0; k < 40; k++) begin
            if (bus.if_valid && bus.if_pc == p) return;
            cyc();
        end
        timeout("wait_pc");
    endtask

    task automatic redirect_to(input logic [31:0] p);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = p;
        cyc();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = 32'h0; bus.ld_last = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.halt_req = 1'b0; bus.if_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = NOP;
`ifndef IMEM_LOADER_EN
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
`endif
        repeat (2) cyc();
        chk("reset_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("reset_if_pc", bus.if_pc, 32'h0);
        chk("reset_state", {30'h0, bus.state}, {30'h0, INIT_ST});
        rst = 1'b0;

`ifdef IMEM_LOADER_EN
        for (int i = 0; i < 8; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 3'(i);
            bus.ld_data  = 32'h1000_0000 + i;
            bus.ld_last  = (i == 7);
            cyc();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("load_we_pulses", we_cnt, 32'd8);
        chk("load_to_run", {30'h0, bus.state}, 32'd1);
        chk("load_pc", bus.imem_addr, 32'h0);
`endif

        // Streaming with wrap back to word 0
        exp_pc = 32'h0;
        for (int k = 0; k < 24 && exp_pc <= 32'h20; k++) begin
            if (bus.if_valid) begin
                chk("stream_pc", bus.if_pc, exp_pc);
                chk("stream_instr", bus.if_instr, 32'h1000_0000 + ((exp_pc >> 2) & 32'h7));
                exp_pc += 32'd4;
            end
            cyc();
        end
        if (exp_pc != 32'h24) timeout("stream");

        // Backpressure at if_pc=8
        redirect_to(32'h0);
        wait_pc(32'h8);
        bus.if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_valid", {31'h0, bus.if_valid}, 32'd1);
            chk("bp_pc", bus.if_pc, 32'h8);
            chk("bp_instr", bus.if_instr, 32'h1000_0002);
            chk("bp_fetch_pc", bus.imem_addr, 32'hC);
        end
        bus.if_ready = 1'b1;
        cyc();
        chk("bp_release", bus.if_pc, 32'hC);

        // Redirect to an unaligned target while if_pc=4 is accepted
        redirect_to(32'h0);
        wait_pc(32'h4);
        redirect_to(32'h15);
        chk("redir_bubble", {31'h0, bus.if_valid}, 32'd0);
        chk("redir_pc", bus.imem_addr, 32'h14);
        cyc();
        chk("redir_valid", {31'h0, bus.if_valid}, 32'd1);
        chk("redir_target", bus.if_pc, 32'h14);
        chk("redir_instr", bus.if_instr, 32'h1000_0005);

        // Halt with a held slot, then resume without skipping
        bus.if_ready = 1'b0;
        bus.halt_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("halt_state", {30'h0, bus.state}, 32'd2);
            chk("halt_slot", bus.if_pc, 32'h14);
            chk("halt_valid", {31'h0, bus.if_valid}, 32'd1);
            chk("halt_pc", bus.imem_addr, 32'h18);
        end
        bus.halt_req = 1'b0;
        bus.if_ready = 1'b1;
        cyc();
        chk("resume_state", {30'h0, bus.state}, 32'd1);
        chk("resume_drain", {31'h0, bus.if_valid}, 32'd0);
        cyc();
        chk("resume_pc", bus.if_pc, 32'h18);

        // Randomized traffic checked by the model
        for (int k = 0; k < 1500; k++) begin
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
            bus.redirect_valid = ($urandom_range(0, 7) == 0);
            bus.redirect_pc    = $urandom;
            cyc();
        end
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.if_ready = 1'b1;

        // Asynchronous reset mid-stream
        redirect_to(32'h0);
        wait_pc(32'h10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, bus.if_valid}, 32'd0);
        chk("arst_pc", bus.imem_addr, 32'h0);
        chk("arst_state", {30'h0, bus.state}, {30'h0, INIT_ST});
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
